// File: rtl/bus_xcvr_sync.sv
// Clocked bidirectional bus transceiver with split in/out/oe ports, registered
// direction control, a guaranteed dead interval on reversals and conflict counting.
module bus_xcvr_sync #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_n,
  input  logic             r_n,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_oe,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] b_out,
  output logic             b_oe,
  output logic             turning,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TC_W-1:0]  TURN_LOAD = TC_W'(TURN_CYCLES - 1);
  localparam logic [TC_W-1:0]  TURN_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0]  TURN_ZERO = {TC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    RECV = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [TC_W-1:0]  turn_cnt_r, turn_cnt_next_s;
  logic             xreq_s, rreq_s, both_s, none_s;
  logic [WIDTH-1:0] a_out_r, b_out_r;
  logic             a_oe_r, b_oe_r, turning_r, conflict_r;
  logic [CNT_W-1:0] conflict_cnt_r;

  // Request decode of the two active-low enables.
  always_comb begin
    xreq_s = ~t_n &  r_n;
    rreq_s =  t_n & ~r_n;
    both_s = ~t_n & ~r_n;
    none_s =  t_n &  r_n;
  end

  // Next-state and turnaround-counter logic; conflicts never change direction.
  always_comb begin
    state_next_s    = state_r;
    turn_cnt_next_s = turn_cnt_r;
    case (state_r)
      IDLE: begin
        if (xreq_s) begin
          state_next_s = XMIT;
        end else if (rreq_s) begin
          state_next_s = RECV;
        end else begin
          state_next_s = IDLE;
        end
      end
      XMIT: begin
        if (rreq_s) begin
          state_next_s    = TURN;
          turn_cnt_next_s = TURN_LOAD;
        end else if (none_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = XMIT;
        end
      end
      RECV: begin
        if (xreq_s) begin
          state_next_s    = TURN;
          turn_cnt_next_s = TURN_LOAD;
        end else if (none_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RECV;
        end
      end
      TURN: begin
        // The dead interval always runs out, whatever the request does meanwhile.
        if (turn_cnt_r != TURN_ZERO) begin
          state_next_s    = TURN;
          turn_cnt_next_s = turn_cnt_r - TURN_ONE;
        end else if (xreq_s) begin
          state_next_s = XMIT;
        end else if (rreq_s) begin
          state_next_s = RECV;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s    = IDLE;
        turn_cnt_next_s = TURN_ZERO;
      end
    endcase
  end

  // State, registered enables/data and conflict bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      turn_cnt_r     <= TURN_ZERO;
      a_oe_r         <= 1'b0;
      b_oe_r         <= 1'b0;
      a_out_r        <= {WIDTH{1'b0}};
      b_out_r        <= {WIDTH{1'b0}};
      turning_r      <= 1'b0;
      conflict_r     <= 1'b0;
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      turn_cnt_r <= turn_cnt_next_s;
      a_oe_r     <= (state_next_s == RECV);
      b_oe_r     <= (state_next_s == XMIT);
      turning_r  <= (state_next_s == TURN);
      conflict_r <= both_s;
      if (state_next_s == XMIT) begin
        b_out_r <= a_in;
      end
      if (state_next_s == RECV) begin
        a_out_r <= b_in;
      end
      if (both_s && (conflict_cnt_r != CNT_MAX)) begin
        conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
      end
    end
  end

  assign a_out        = a_out_r;
  assign b_out        = b_out_r;
  assign a_oe         = a_oe_r;
  assign b_oe         = b_oe_r;
  assign turning      = turning_r;
  assign conflict     = conflict_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_bus_xcvr_sync.sv
// Scoreboard bench: two transceivers (TURN_CYCLES=1/CNT_W=8 and TURN_CYCLES=3/CNT_W=2)
// share stimulus; a direction/dead-time model predicts every cycle's outputs.
module tb_bus_xcvr_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       t_n = 1'b1;
  logic       r_n = 1'b1;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;

  logic [7:0] a_out1, b_out1, cnt1;
  logic       a_oe1, b_oe1, turning1, conflict1;
  logic [7:0] a_out3, b_out3;
  logic [1:0] cnt3;
  logic       a_oe3, b_oe3, turning3, conflict3;

  bus_xcvr_sync #(.WIDTH(8), .TURN_CYCLES(1), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .t_n(t_n), .r_n(r_n),
    .a_in(a_in), .a_out(a_out1), .a_oe(a_oe1),
    .b_in(b_in), .b_out(b_out1), .b_oe(b_oe1),
    .turning(turning1), .conflict(conflict1), .conflict_cnt(cnt1)
  );

  bus_xcvr_sync #(.WIDTH(8), .TURN_CYCLES(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .t_n(t_n), .r_n(r_n),
    .a_in(a_in), .a_out(a_out3), .a_oe(a_oe3),
    .b_in(b_in), .b_out(b_out3), .b_oe(b_oe3),
    .turning(turning3), .conflict(conflict3), .conflict_cnt(cnt3)
  );

  // {a_oe, b_oe, turning, conflict, a_out, b_out, conflict_cnt}
  typedef logic [27:0] obs_t;
  obs_t obs1, obs3;
  assign obs1 = {a_oe1, b_oe1, turning1, conflict1, a_out1, b_out1, cnt1};
  assign obs3 = {a_oe3, b_oe3, turning3, conflict3, a_out3, b_out3, 6'd0, cnt3};

  obs_t q1[$];
  obs_t q3[$];
  int total = 0;
  int bad   = 0;

  // Model: direction 0=none,1=A->B,2=B->A plus a count of dead cycles still owed.
  int         m_dir[2];
  int         m_dead[2];
  int         m_cnt[2];
  logic [7:0] m_a[2];
  logic [7:0] m_b[2];
  logic       m_conf[2];

  function automatic obs_t model_step(int k, int tc, int cw);
    bit x, rq, bo, nn;
    int sat;
    sat = (1 << cw) - 1;
    if (reset) begin
      m_dir[k] = 0; m_dead[k] = 0; m_cnt[k] = 0;
      m_a[k] = 8'h00; m_b[k] = 8'h00; m_conf[k] = 1'b0;
    end else begin
      x  = !t_n &&  r_n;
      rq =  t_n && !r_n;
      bo = !t_n && !r_n;
      nn =  t_n &&  r_n;
      m_conf[k] = bo;
      if (bo && m_cnt[k] < sat) m_cnt[k]++;
      if (m_dead[k] > 1) begin
        m_dead[k]--;
      end else if (m_dead[k] == 1 || m_dir[k] == 0) begin
        m_dead[k] = 0;
        m_dir[k]  = x ? 1 : (rq ? 2 : 0);
      end else if ((m_dir[k] == 1 && rq) || (m_dir[k] == 2 && x)) begin
        m_dead[k] = tc;
        m_dir[k]  = 0;
      end else if (nn) begin
        m_dir[k] = 0;
      end
      if (m_dead[k] == 0 && m_dir[k] == 1) m_b[k] = a_in;
      if (m_dead[k] == 0 && m_dir[k] == 2) m_a[k] = b_in;
    end
    return {(m_dir[k] == 2 && m_dead[k] == 0), (m_dir[k] == 1 && m_dead[k] == 0),
            (m_dead[k] > 0), m_conf[k], m_a[k], m_b[k], 8'(m_cnt[k])};
  endfunction

  // Drive one cycle of stimulus at the falling edge; predict at the rising edge.
  task automatic cycle(input logic rst, input logic t, input logic r,
                       input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    reset = rst; t_n = t; r_n = r; a_in = a; b_in = b;
    @(posedge clk);
    q1.push_back(model_step(0, 1, 8));
    q3.push_back(model_step(1, 3, 2));
  endtask

  task automatic rcycle(input logic rst, input logic t, input logic r);
    cycle(rst, t, r, 8'($urandom), 8'($urandom));
  endtask

  logic p_a1 = 1'b0, p_b1 = 1'b0, p_a3 = 1'b0, p_b3 = 1'b0;

  // Monitor: compare every presented cycle against the queued prediction.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      total++;
      if (obs1 !== e) begin
        bad++;
        $display("FAIL tc1_outputs t=%0t got=%h expected=%h", $time, obs1, e);
      end
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      total++;
      if (obs3 !== e) begin
        bad++;
        $display("FAIL tc3_outputs t=%0t got=%h expected=%h", $time, obs3, e);
      end
    end
    total++;
    if ((a_oe1 & b_oe1) || (a_oe3 & b_oe3)) begin
      bad++;
      $display("FAIL oe_overlap t=%0t got=%b%b/%b%b expected no overlap",
               $time, a_oe1, b_oe1, a_oe3, b_oe3);
    end
    total++;
    if ((a_oe1 && p_b1) || (b_oe1 && p_a1) || (a_oe3 && p_b3) || (b_oe3 && p_a3)) begin
      bad++;
      $display("FAIL dead_gap t=%0t got=direct handover expected>=1 dead cycle", $time);
    end
    p_a1 = a_oe1; p_b1 = b_oe1; p_a3 = a_oe3; p_b3 = b_oe3;
  end

  initial begin
    logic t, r;
    int guard;
    // Reset, then transmit A5 and 3C.
    rcycle(1'b1, 1'b1, 1'b1);
    rcycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h3C, 8'h22);
    cycle(1'b0, 1'b0, 1'b1, 8'h3C, 8'h33);
    // Reversal to receive with b_in=5A.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h77, 8'h5A);
    // Back to transmit, then a one-cycle reversal pulse that must still run TURN out.
    for (int i = 0; i < 5; i++) rcycle(1'b0, 1'b0, 1'b1);
    rcycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rcycle(1'b0, 1'b0, 1'b1);
    // Idle, then five conflict cycles (saturates the 2-bit counter).
    for (int i = 0; i < 2; i++) rcycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) rcycle(1'b0, 1'b0, 1'b0);
    // Conflict while receiving holds the receive direction.
    for (int i = 0; i < 2; i++) rcycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) rcycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) rcycle(1'b0, 1'b1, 1'b0);
    // Reset during transmit with the request held.
    for (int i = 0; i < 3; i++) rcycle(1'b0, 1'b0, 1'b1);
    rcycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rcycle(1'b0, 1'b0, 1'b1);
    // Randomised request sequences with occasional reset.
    t = 1'b1; r = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        t = 1'($urandom);
        r = 1'($urandom);
      end
      rcycle(($urandom_range(499, 0) == 0) ? 1'b1 : 1'b0, t, r);
    end
    guard = 0;
    while ((q1.size() > 0 || q3.size() > 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (q1.size() > 0 || q3.size() > 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d pending expected=0", q1.size(), q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
